serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl.sv | 114 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell reused across WIDTH cycles, LSB first.
// Defining SERIAL_ADD_OVF_EN adds a registered signed-overflow output.

module serial_adder_fa (
   input  logic a,
   input  logic b,
   input  logic carryin,
   output logic sum,
   output logic carryout
);
   assign sum      = a ^ b ^ carryin;
   assign carryout = (a & b) | (carryin & (a ^ b));
endmodule

// state | meaning
// IDLE  | waiting for start, result registers hold last result
// RUN   | one operand bit pair consumed per edge, LSB first
// DONE  | one-cycle result-valid pulse; start here is accepted back-to-back
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carryin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carryout
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             overflow
`endif
);
   localparam int IW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             carry;
   logic [IW-1:0]    idx;
   logic             fa_sum;
   logic             fa_co;
   logic             last_bit;
   logic             accept;

   serial_adder_fa u_fa (
      .a        (a_sh[0]),
      .b        (b_sh[0]),
      .carryin  (carry),
      .sum      (fa_sum),
      .carryout (fa_co)
   );

   assign last_bit = (idx == IW'(WIDTH - 1));
   assign accept   = start && (state != RUN);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last_bit) state_nxt = DONE;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   // Result bits enter from the MSB so sum is aligned after exactly WIDTH shifts.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_sh     <= '0;
         b_sh     <= '0;
         carry    <= 1'b0;
         idx      <= '0;
         sum      <= '0;
         carryout <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         overflow <= 1'b0;
`endif
      end else if (accept) begin
         a_sh  <= a;
         b_sh  <= b;
         carry <= carryin;
         idx   <= '0;
      end else if (state == RUN) begin
         a_sh  <= a_sh >> 1;
         b_sh  <= b_sh >> 1;
         sum   <= {fa_sum, sum[WIDTH-1:1]};
         carry <= fa_co;
         idx   <= idx + IW'(1);
         if (last_bit) begin
            carryout <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
            overflow <= carry ^ fa_co;
`endif
         end
      end
   end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8) with a cycle-level arithmetic model
// checked every cycle plus literal expectations for the key scenarios.
`timescale 1ns/1ps
module tb_serial_adder_ctrl;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         carryin = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         carryout;
`ifdef SERIAL_ADD_OVF_EN
   logic         overflow;
`endif

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .a        (a),
      .b        (b),
      .carryin  (carryin),
      .busy     (busy),
      .done     (done),
      .sum      (sum),
      .carryout (carryout)
`ifdef SERIAL_ADD_OVF_EN
      ,
      .overflow (overflow)
`endif
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: an operation lasts W edges after acceptance, then the result is a+b+cin.
   int         rem = 0;
   logic [W:0] pend = '0;
   logic [W:0] res = '0;
   logic       ovf_pend = 1'b0;
   logic       ovf_res = 1'b0;
   logic       done_m = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         rem = 0; res = '0; ovf_res = 1'b0; done_m = 1'b0;
      end else begin
         done_m = 1'b0;
         if (rem > 0) begin
            rem--;
            if (rem == 0) begin
               res = pend; ovf_res = ovf_pend; done_m = 1'b1;
            end
         end else if (start) begin
            rem = W;
            pend = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, carryin};
            ovf_pend = (a[W-1] == b[W-1]) && (pend[W-1] != a[W-1]);
         end
      end
   end

   always @(negedge clk) begin
      check("busy", busy, (rem > 0));
      check("done", done, done_m);
      if (rem == 0) begin
         check("sum", sum, res[W-1:0]);
         check("carryout", carryout, res[W]);
`ifdef SERIAL_ADD_OVF_EN
         check("overflow", overflow, ovf_res);
`endif
      end
   end

   task automatic go(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
      @(negedge clk);
      a = va; b = vb; carryin = vc; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("done_timeout", done, 1'b1);
   endtask

   int n;
   int extra;

   initial begin
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("rst_sum", sum, 8'h00);
      check("rst_busy", busy, 1'b0);

      // 0x0F + 0x01: busy for 8 cycles, done on the 8th edge after acceptance
      go(8'h0F, 8'h01, 1'b0);
      check("busy_first", busy, 1'b1);
      wait_done(n);
      check("latency", n, 8);
      check("lit_0f01_sum", sum, 8'h10);
      check("lit_0f01_co", carryout, 1'b0);

      go(8'hFF, 8'h01, 1'b0);
      wait_done(n);
      check("lit_ff01_sum", sum, 8'h00);
      check("lit_ff01_co", carryout, 1'b1);
`ifdef SERIAL_ADD_OVF_EN
      check("lit_ff01_ovf", overflow, 1'b0);
`endif

      go(8'h7F, 8'h01, 1'b0);
      wait_done(n);
      check("lit_7f01_sum", sum, 8'h80);
      check("lit_7f01_co", carryout, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
      check("lit_7f01_ovf", overflow, 1'b1);
`endif

      // back-to-back: start asserted during the DONE cycle
      go(8'hFF, 8'hFF, 1'b1);
      wait_done(n);
      check("lit_ffff_sum", sum, 8'hFF);
      check("lit_ffff_co", carryout, 1'b1);
      a = 8'h01; b = 8'h02; carryin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("b2b_busy", busy, 1'b1);
      check("b2b_done_drop", done, 1'b0);
      wait_done(n);
      check("b2b_latency", n, 8);
      check("lit_0102_sum", sum, 8'h03);
      check("lit_0102_co", carryout, 1'b0);

      // start during RUN is ignored
      go(8'h01, 8'h01, 1'b0);
      @(negedge clk);
      a = 8'hAA; b = 8'h55; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(n);
      check("lit_ignore_sum", sum, 8'h02);
      extra = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) extra++;
      end
      check("no_second_done", extra, 0);

      // reset mid-RUN aborts the operation
      go(8'h0F, 8'h0F, 1'b1);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_sum", sum, 8'h00);
      check("abort_co", carryout, 1'b0);
      go(8'h05, 8'h03, 1'b0);
      wait_done(n);
      check("abort_latency", n, 8);
      check("lit_0503_sum", sum, 8'h08);

      // reset wins over start on the same edge
      @(negedge clk);
      reset = 1'b1; start = 1'b1; a = 8'h12; b = 8'h34; carryin = 1'b1;
      @(negedge clk);
      check("rst_prio_busy", busy, 1'b0);
      reset = 1'b0;
      @(negedge clk);
      start = 1'b0;
      check("rst_then_start", busy, 1'b1);
      wait_done(n);
      check("lit_1234_sum", sum, 8'h47);

      go(8'h80, 8'h80, 1'b0);
      wait_done(n);
      check("lit_8080_sum", sum, 8'h00);
      check("lit_8080_co", carryout, 1'b1);
      go(8'h55, 8'hAA, 1'b1);
      wait_done(n);
      check("lit_55aa_sum", sum, 8'h00);
      check("lit_55aa_co", carryout, 1'b1);
      go(8'h3C, 8'h0A, 1'b1);
      wait_done(n);
      check("lit_3c0a_sum", sum, 8'h47);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
